div8_seq: RTL and testbench



---
 rtl/div8_seq.sv | 111 +++++++++++
 tb/tb_div8_seq.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/div8_seq.sv
// rtl/div8_seq.sv - sequential 8-bit restoring divider driving one shared SCS stage

module scs8 (
  input  logic [7:0] p,
  input  logic [7:0] d,
  output logic       q_bit,
  output logic [7:0] rout
);
  logic [8:0] diff;

  // diff[8] is the subtractor borrow-out; no borrow means the divisor fits
  assign diff  = {1'b0, p} - {1'b0, d};
  assign q_bit = ~diff[8];
  assign rout  = q_bit ? diff[7:0] : p;
endmodule

module div8_seq #(
  parameter int STATE_BITS = 2,
  parameter int STEP_BITS  = 3
) (
  input  logic       drv_clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       dbz
);
  typedef enum logic [STATE_BITS-1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_nx;
  logic [STEP_BITS-1:0] step;
  logic [7:0]           rem_r, quo_r, div_r;
  logic                 dbz_r;
  logic [7:0]           p, rout;
  logic                 q_bit;

  // next dividend bit enters the partial remainder from the top of quo_r
  assign p = {rem_r[6:0], quo_r[7]};

  scs8 u_scs (
    .p     (p),
    .d     (div_r),
    .q_bit (q_bit),
    .rout  (rout)
  );

  always_ff @(posedge drv_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = (divisor == 8'd0) ? DONE : CALC;
      CALC: begin
        busy = 1'b1;
        if (&step) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge drv_clk) begin
    if (reset) begin
      step  <= '0;
      rem_r <= 8'd0;
      quo_r <= 8'd0;
      div_r <= 8'd0;
      dbz_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor != 8'd0) begin
              div_r <= divisor;
              quo_r <= dividend;
              rem_r <= 8'd0;
              step  <= '0;
            end else begin
              rem_r <= dividend;
              quo_r <= 8'hFF;
              dbz_r <= 1'b1;
            end
          end
        end
        CALC: begin
          rem_r <= rout;
          quo_r <= {quo_r[6:0], q_bit};
          step  <= step + 1'b1;
          if (&step) dbz_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign quotient  = quo_r;
  assign remainder = rem_r;
  assign dbz       = dbz_r;
endmodule

// File: tb/tb_div8_seq.sv
// tb/tb_div8_seq.sv - vector-table and sequence bench for div8_seq

module tb_div8_seq;
  logic       drv_clk = 1'b0;
  logic       reset, start;
  logic [7:0] dividend, divisor;
  logic       busy, done, dbz;
  logic [7:0] quotient, remainder;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] dd;
    logic [7:0] dv;
    logic [7:0] eq;
    logic [7:0] er;
    logic       edbz;
  } vec_t;

  vec_t vt[$];

  div8_seq dut (
    .drv_clk   (drv_clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  always #5 drv_clk = ~drv_clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Issues one operation from a negedge in IDLE/DONE and returns in the done cycle.
  // glitch_k >= 0 pulses a competing start (9/2) during that cycle after E0.
  task automatic run_op(input logic [7:0] dd, input logic [7:0] dv, input logic [7:0] eq,
                        input logic [7:0] er, input logic edbz, input int glitch_k);
    int k, bc, exp_k;
    @(negedge drv_clk);
    chk("idle_done_low", done, 0);
    start = 1'b1; dividend = dd; divisor = dv;
    @(posedge drv_clk);
    @(negedge drv_clk);
    start = 1'b0;
    k = 0; bc = 0;
    exp_k = edbz ? 0 : 8;
    while (!done && k < 20) begin
      if (busy) bc++;
      if (k == glitch_k) begin
        start = 1'b1; dividend = 8'd9; divisor = 8'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge drv_clk);
      k++;
    end
    start = 1'b0;
    chk($sformatf("latency %0d/%0d", dd, dv), k, exp_k);
    chk($sformatf("busy_cycles %0d/%0d", dd, dv), bc, edbz ? 0 : 8);
    chk($sformatf("busy_in_done %0d/%0d", dd, dv), busy, 0);
    chk($sformatf("quotient %0d/%0d", dd, dv), quotient, eq);
    chk($sformatf("remainder %0d/%0d", dd, dv), remainder, er);
    chk($sformatf("dbz %0d/%0d", dd, dv), dbz, edbz);
  endtask

  initial begin
    int quiet;
    logic [7:0] rd, rv;

    vt.push_back('{8'd200, 8'd7,   8'd28,  8'd4,  1'b0});
    vt.push_back('{8'd255, 8'd1,   8'd255, 8'd0,  1'b0});
    vt.push_back('{8'd5,   8'd9,   8'd0,   8'd5,  1'b0});
    vt.push_back('{8'd255, 8'd200, 8'd1,   8'd55, 1'b0});
    vt.push_back('{8'd77,  8'd0,   8'hFF,  8'd77, 1'b1});
    vt.push_back('{8'd77,  8'd5,   8'd15,  8'd2,  1'b0});
    vt.push_back('{8'd0,   8'd5,   8'd0,   8'd0,  1'b0});
    vt.push_back('{8'd255, 8'd255, 8'd1,   8'd0,  1'b0});
    vt.push_back('{8'd128, 8'd2,   8'd64,  8'd0,  1'b0});
    vt.push_back('{8'd1,   8'd255, 8'd0,   8'd1,  1'b0});
    vt.push_back('{8'd0,   8'd0,   8'hFF,  8'd0,  1'b1});

    reset = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
    repeat (2) @(negedge drv_clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_dbz", dbz, 0);
    reset = 1'b0;

    foreach (vt[i]) run_op(vt[i].dd, vt[i].dv, vt[i].eq, vt[i].er, vt[i].edbz, -1);

    // competing start mid-calculation must be dropped
    run_op(8'd100, 8'd3, 8'd33, 8'd1, 1'b0, 3);
    @(negedge drv_clk);
    chk("glitch_not_queued_busy", busy, 0);
    chk("glitch_not_queued_done", done, 0);

    // reset at step 4 of 250/13 discards the operation
    @(negedge drv_clk);
    start = 1'b1; dividend = 8'd250; divisor = 8'd13;
    @(posedge drv_clk);
    @(negedge drv_clk);
    start = 1'b0;
    repeat (4) @(negedge drv_clk);
    reset = 1'b1;
    @(negedge drv_clk);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_quotient", quotient, 0);
    chk("midreset_remainder", remainder, 0);
    chk("midreset_dbz", dbz, 0);
    reset = 1'b0;
    quiet = 0;
    repeat (10) begin
      @(negedge drv_clk);
      if (done || busy) quiet++;
    end
    chk("midreset_no_done", quiet, 0);
    run_op(8'd250, 8'd13, 8'd19, 8'd3, 1'b0, -1);

    for (int i = 0; i < 300; i++) begin
      rd = 8'($urandom_range(0, 255));
      rv = (i % 25 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if (rv == 8'd0) run_op(rd, rv, 8'hFF, rd, 1'b1, -1);
      else            run_op(rd, rv, rd / rv, rd % rv, 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
